// File: rtl/dff_stream_checker_if.sv
// Observation and result bundle between a register under test and its stream checker.
// The master side drives the run request and observed data; the slave side (the checker) returns results.
interface dff_stream_checker_if #(
  parameter int ERR_W = 8,
  parameter int IDX_W = 5
);
  logic             start;
  logic             d_obs;
  logic             q_obs;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic             first_err_vld;
  logic [IDX_W-1:0] first_err_idx;

  modport master (
    output start, d_obs, q_obs,
    input  busy, done, pass, err_cnt, first_err_vld, first_err_idx
  );

  modport slave (
    input  start, d_obs, q_obs,
    output busy, done, pass, err_cnt, first_err_vld, first_err_idx
  );
endinterface

// File: rtl/dff_stream_checker.sv
// Scores a one-cycle register by comparing q_obs against d_obs from the previous edge over CHECK_LEN compares.
// Verdict valid CHECK_LEN+2 cycles after start; start is ignored while busy and never queued.
module dff_stream_checker #(
  parameter int CHECK_LEN = 16,
  parameter int ERR_W     = 8,
  parameter int IDX_W     = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  dff_stream_checker_if.slave chk
);

  typedef enum logic [1:0] {IDLE, PRIME, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic             exp_q, exp_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fev_q, fev_d;
  logic [IDX_W-1:0] fei_q, fei_d;
  logic             busy_q, done_q, pass_q;
  logic             launch, mismatch, last;

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    idx_d    = idx_q;
    err_d    = err_q;
    fev_d    = fev_q;
    fei_d    = fei_q;
    mismatch = 1'b0;
    launch   = chk.start && ((state_q == IDLE) || (state_q == DONE));
    last     = (idx_q == IDX_W'(CHECK_LEN - 1));

    case (state_q)
      IDLE, DONE: begin
        if (launch) begin
          state_d = PRIME;
          err_d   = '0;
          fev_d   = 1'b0;
          fei_d   = '0;
        end
      end
      PRIME: begin
        exp_d   = chk.d_obs;
        idx_d   = '0;
        state_d = CHECK;
      end
      CHECK: begin
        mismatch = (chk.q_obs != exp_q);
        exp_d    = chk.d_obs;
        idx_d    = idx_q + IDX_W'(1);
        if (last) state_d = DONE;
        // Counter saturates; first-failure index latches the pre-increment compare index
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + ERR_W'(1);
          if (!fev_q) begin
            fev_d = 1'b1;
            fei_d = idx_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      exp_q   <= 1'b0;
      idx_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fei_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fei_q   <= fei_d;
      busy_q  <= (state_d == PRIME) || (state_d == CHECK);
      done_q  <= (state_d == DONE);
      pass_q  <= (state_d == DONE) && (err_d == '0);
    end
  end

  assign chk.busy          = busy_q;
  assign chk.done          = done_q;
  assign chk.pass          = pass_q;
  assign chk.err_cnt       = err_q;
  assign chk.first_err_vld = fev_q;
  assign chk.first_err_idx = fei_q;

endmodule

// File: tb/tb_dff_stream_checker.sv
// Directed bench for dff_stream_checker: main (16/8/5), saturating (16/3/5) and single-compare (1/8/1) instances.
module tb_dff_stream_checker;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  dff_stream_checker_if #(.ERR_W(8), .IDX_W(5)) m_if ();
  dff_stream_checker_if #(.ERR_W(3), .IDX_W(5)) s_if ();
  dff_stream_checker_if #(.ERR_W(8), .IDX_W(1)) sh_if ();

  dff_stream_checker #(.CHECK_LEN(16), .ERR_W(8), .IDX_W(5)) u_main (
    .clk(clk), .rst_n(rst_n), .chk(m_if)
  );
  dff_stream_checker #(.CHECK_LEN(16), .ERR_W(3), .IDX_W(5)) u_sat (
    .clk(clk), .rst_n(rst_n), .chk(s_if)
  );
  dff_stream_checker #(.CHECK_LEN(1), .ERR_W(8), .IDX_W(1)) u_short (
    .clk(clk), .rst_n(rst_n), .chk(sh_if)
  );

  // Registers under test: a correct DFF with optional inversion/tie-off for the main checker
  logic m_q = 1'b0;
  logic sh_q = 1'b0;
  logic tie0 = 1'b0;
  logic inv = 1'b0;
  always @(posedge clk) m_q <= m_if.d_obs;
  always @(posedge clk) sh_q <= sh_if.d_obs;
  assign m_if.q_obs  = tie0 ? 1'b0 : (m_q ^ inv);
  assign s_if.q_obs  = 1'b0;
  assign sh_if.q_obs = sh_q;

  localparam logic [16:0] PAT = 17'b1_1100_1010_0110_1101;
  logic [16:0] pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full main-checker run starting at a negedge; N(j) is the j-th negedge after the start edge
  task automatic run_main(input logic [16:0] p, input logic [15:0] mask,
                          input int spurious_at, input string tag);
    m_if.start = 1'b1;
    @(negedge clk);
    m_if.start = 1'b0;
    for (int j = 0; j <= 16; j++) begin
      if (j > 0) @(negedge clk);
      chk({tag, " busy"}, m_if.busy, 1);
      chk({tag, " done_low"}, m_if.done, 0);
      if (j == 0) begin
        chk({tag, " clr_err"}, m_if.err_cnt, 0);
        chk({tag, " clr_fev"}, m_if.first_err_vld, 0);
        chk({tag, " clr_pass"}, m_if.pass, 0);
      end
      m_if.d_obs = p[j];
      inv        = (j > 0) ? mask[j-1] : 1'b0;
      m_if.start = (j == spurious_at);
    end
    @(negedge clk);
    inv        = 1'b0;
    m_if.start = 1'b0;
    chk({tag, " done"}, m_if.done, 1);
    chk({tag, " busy_low"}, m_if.busy, 0);
  endtask

  initial begin
    pat         = PAT;
    m_if.start  = 1'b0;
    m_if.d_obs  = 1'b0;
    s_if.start  = 1'b0;
    s_if.d_obs  = 1'b1;
    sh_if.start = 1'b0;
    sh_if.d_obs = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy", m_if.busy, 0);
    chk("rst done", m_if.done, 0);
    chk("rst pass", m_if.pass, 0);
    chk("rst err", m_if.err_cnt, 0);
    chk("rst fev", m_if.first_err_vld, 0);
    chk("rst fei", m_if.first_err_idx, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle done", m_if.done, 0);
    chk("idle busy", m_if.busy, 0);

    // Correct DFF, clean run
    run_main(pat, 16'h0000, -1, "clean");
    chk("clean pass", m_if.pass, 1);
    chk("clean err", m_if.err_cnt, 0);
    chk("clean fev", m_if.first_err_vld, 0);

    // q tied low, d held high: every compare fails
    tie0 = 1'b1;
    run_main(17'h1FFFF, 16'h0000, -1, "tie0");
    tie0 = 1'b0;
    chk("tie0 err", m_if.err_cnt, 16);
    chk("tie0 fev", m_if.first_err_vld, 1);
    chk("tie0 fei", m_if.first_err_idx, 0);
    chk("tie0 pass", m_if.pass, 0);

    // Single inversion at compare 5
    run_main(pat, 16'h0020, -1, "inv5");
    chk("inv5 err", m_if.err_cnt, 1);
    chk("inv5 fev", m_if.first_err_vld, 1);
    chk("inv5 fei", m_if.first_err_idx, 5);
    chk("inv5 pass", m_if.pass, 0);

    // Single inversion on the last compare
    run_main(pat, 16'h8000, -1, "inv15");
    chk("inv15 err", m_if.err_cnt, 1);
    chk("inv15 fei", m_if.first_err_idx, 15);
    chk("inv15 pass", m_if.pass, 0);

    // Spurious start mid-CHECK is ignored; later errors keep the first index
    run_main(pat, 16'h0108, 5, "spur");
    chk("spur err", m_if.err_cnt, 2);
    chk("spur fei", m_if.first_err_idx, 3);
    chk("spur pass", m_if.pass, 0);
    repeat (3) @(negedge clk);
    chk("hold done", m_if.done, 1);
    chk("hold err", m_if.err_cnt, 2);

    // Restart from DONE with a correct DFF
    run_main(pat, 16'h0000, -1, "rerun");
    chk("rerun pass", m_if.pass, 1);
    chk("rerun err", m_if.err_cnt, 0);

    // Asynchronous reset at compare index 8 after two mismatches
    m_if.start = 1'b1;
    @(negedge clk);
    m_if.start = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      if (j > 0) @(negedge clk);
      m_if.d_obs = pat[j];
      inv        = (j > 0) ? ((j - 1 == 2) || (j - 1 == 5)) : 1'b0;
    end
    @(negedge clk);
    inv = 1'b0;
    chk("pre_rst err", m_if.err_cnt, 2);
    chk("pre_rst fei", m_if.first_err_idx, 2);
    rst_n = 1'b0;
    #1;
    chk("arst busy", m_if.busy, 0);
    chk("arst done", m_if.done, 0);
    chk("arst pass", m_if.pass, 0);
    chk("arst err", m_if.err_cnt, 0);
    chk("arst fev", m_if.first_err_vld, 0);
    chk("arst fei", m_if.first_err_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst busy", m_if.busy, 0);
    chk("post_rst done", m_if.done, 0);

    // Saturation with a 3-bit counter
    s_if.start = 1'b1;
    @(negedge clk);
    s_if.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("sat mid err", s_if.err_cnt, 7);
    chk("sat mid busy", s_if.busy, 1);
    repeat (7) @(negedge clk);
    chk("sat done", s_if.done, 1);
    chk("sat err", s_if.err_cnt, 7);
    chk("sat fev", s_if.first_err_vld, 1);
    chk("sat fei", s_if.first_err_idx, 0);
    chk("sat pass", s_if.pass, 0);

    // Single-compare run
    sh_if.start = 1'b1;
    @(negedge clk);
    sh_if.start = 1'b0;
    sh_if.d_obs = 1'b1;
    chk("short busy0", sh_if.busy, 1);
    @(negedge clk);
    sh_if.d_obs = 1'b0;
    chk("short busy1", sh_if.busy, 1);
    chk("short done1", sh_if.done, 0);
    @(negedge clk);
    chk("short done", sh_if.done, 1);
    chk("short pass", sh_if.pass, 1);
    chk("short busy", sh_if.busy, 0);
    chk("short err", sh_if.err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
